axis_in_router: RTL and testbench
=================================

AXIS_IN_ROUTER -- requirements
Module: axis_in_router

Interface
REQ-001 SHALL have parameter DATA_W, default 64: stream data width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: beat-counter and config width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_weight_dma_req, input, 1: route select; 1 selects weight, 0 selects activation; sampled only at frame start.
REQ-006 SHALL have port cfg_wgt_beats, input, CNT_W: expected beats per weight frame; 0 means tlast-only.
REQ-007 SHALL have port cfg_act_beats, input, CNT_W: expected beats per activation frame; 0 means tlast-only.
REQ-008 SHALL have ports s_axis_tdata/tvalid/tready/tlast, input/input/output/input, DATA_W/1/1/1: host AXI-Stream slave.
REQ-009 SHALL have ports m_wgt_tdata/tvalid/tready, output/output/input, DATA_W/1/1: to the weight buffer.
REQ-010 SHALL have ports m_act_tdata/tvalid/tready/tlast, output/output/input/output, DATA_W/1/1/1: to the input buffer.
REQ-011 SHALL have ports o_wgt_done and o_act_done, output, 1 each: one-cycle frame-complete pulses.
REQ-012 SHALL have port o_err_len, output, 1: sticky flag for frame-length/tlast mismatch.
REQ-013 SHALL have port i_err_clr, input, 1: clears o_err_len.

Function
REQ-014 SHALL implement FSM IDLE, WGT, ACT; IDLE->WGT or IDLE->ACT on first accepted beat, per i_weight_dma_req in that cycle; WGT/ACT->IDLE on accepted frame-end beat.
REQ-015 SHALL treat a single-beat frame, where the first beat is also frame-end, as entering and leaving the state in that same cycle, ending in IDLE.
REQ-016 SHALL define frame-end as the first accepted beat with tlast=1 or beat count reaching cfg beats (non-zero cfg), whichever comes first.
REQ-017 SHALL set o_err_len when the frame ends with tlast=1 and count != cfg, or the count reaches cfg with tlast=0; with cfg=0 no error is flagged.
REQ-018 SHALL sample cfg_*_beats at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-019 SHALL hold i_weight_dma_req changes mid-frame without effect.
REQ-020 SHALL pass beats through one output register: 1 cycle latency from s_axis handshake to m_* tvalid.
REQ-021 SHALL tag each output register entry with a destination bit; only that destination's tvalid is asserted; the other tvalid is 0.
REQ-022 SHALL drive s_axis_tready = !obuf_valid | tready of the tagged destination, giving full throughput with no bubble under continuous ready.
REQ-023 SHALL hold m_* tdata and tvalid stable while tvalid=1 and tready=0.
REQ-024 SHALL drive m_act_tlast=1 on the frame-end beat of an activation frame, including count-terminated frames.
REQ-025 SHALL pulse o_wgt_done or o_act_done one cycle after the frame-end beat's handshake with its destination.
REQ-026 SHALL give the clear priority when i_err_clr and a new error occur in the same cycle: the flag ends the cycle at 0, and the new error is lost.
REQ-027 SHALL size the beat counter at CNT_W, saturating at all-ones in tlast-only mode.

Reset
REQ-028 SHALL, when rst=1, set the FSM to IDLE, clear the counter, obuf_valid, m_*_tvalid, m_act_tlast, done pulses and o_err_len, and drive s_axis_tready=0.
REQ-029 SHALL discard any in-flight beat on a mid-frame reset; the next beat after reset starts a new frame.

Structure
REQ-030 SHALL place FSM state encodings and the DEST_WGT/DEST_ACT constants in the shared params include.
REQ-031 SHALL use no sub-module; the output register stays inline, because a reusable skid register is not warranted.

Verification
REQ-032 SHALL cover: req=1, cfg_wgt_beats=4, 4 beats with tlast on beat 4 -> 4 beats on m_wgt, 1 o_wgt_done pulse, o_err_len=0.
REQ-033 SHALL cover: req=0, cfg_act_beats=3, 3 beats with tlast on beat 2 -> frame ends at beat 2 with m_act_tlast=1, o_err_len=1; beat 3 starts a new frame.
REQ-034 SHALL cover: m_act_tready toggling 1010 over an 8-beat frame -> all 8 beats delivered in order, data held while stalled, no loss or duplication.
REQ-035 SHALL cover: req flipped 0->1 mid activation frame -> the remaining beats go to m_act, and the next frame goes to m_wgt.
REQ-036 SHALL cover: rst pulsed after beat 2 of 4 -> all outputs 0 the next cycle, and a fresh 4-beat frame completes correctly.
REQ-037 SHALL cover: cfg_act_beats=0, 300-beat frame with tlast -> no error, one o_act_done pulse.

Source files
------------

// File: rtl/axis_in_router_pkg.sv
// rtl/axis_in_router_pkg.sv - shared state encodings and destination tags for the input router
package axis_in_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WGT  = 2'd1,
        ST_ACT  = 2'd2
    } state_e;

    localparam logic DEST_WGT = 1'b1;
    localparam logic DEST_ACT = 1'b0;

endpackage

// File: rtl/axis_in_router.sv
// rtl/axis_in_router.sv - steers host stream frames to the weight or activation buffer
// through a single tagged output register, with frame-length checking.
module axis_in_router
    import axis_in_router_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_weight_dma_req,
    input  logic [CNT_W-1:0]  cfg_wgt_beats,
    input  logic [CNT_W-1:0]  cfg_act_beats,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_wgt_tdata,
    output logic              m_wgt_tvalid,
    input  logic              m_wgt_tready,
    output logic [DATA_W-1:0] m_act_tdata,
    output logic              m_act_tvalid,
    input  logic              m_act_tready,
    output logic              m_act_tlast,
    output logic              o_wgt_done,
    output logic              o_act_done,
    output logic              o_err_len,
    input  logic              i_err_clr
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cfg_q, cfg_d;
    logic [DATA_W-1:0]   obuf_data_q;
    logic                obuf_valid_q, obuf_dest_q, obuf_last_q;
    logic                wgt_done_q, act_done_q, err_q;
    logic                dest_d, dest_ready, out_fire, in_fire, first_beat;
    logic                cnt_hit, frame_end, len_err;

    assign dest_ready    = (obuf_dest_q == DEST_WGT) ? m_wgt_tready : m_act_tready;
    assign out_fire      = obuf_valid_q && dest_ready;
    assign s_axis_tready = !rst && (!obuf_valid_q || dest_ready);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign first_beat    = (state_q == ST_IDLE);

    // Route and length limit are latched on the first beat; later beats follow the frame.
    always_comb begin
        dest_d = DEST_ACT;
        cfg_d  = cfg_q;
        cnt_d  = cnt_q;
        if (first_beat) begin
            dest_d = i_weight_dma_req ? DEST_WGT : DEST_ACT;
            cfg_d  = i_weight_dma_req ? cfg_wgt_beats : cfg_act_beats;
            cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            dest_d = (state_q == ST_WGT) ? DEST_WGT : DEST_ACT;
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign cnt_hit   = (cfg_d != '0) && (cnt_d == cfg_d);
    assign frame_end = s_axis_tlast || cnt_hit;
    // Mismatch whenever tlast and the count limit disagree on where the frame ends.
    assign len_err   = (cfg_d != '0) && (s_axis_tlast != cnt_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cfg_q        <= '0;
            obuf_data_q  <= '0;
            obuf_valid_q <= 1'b0;
            obuf_dest_q  <= DEST_ACT;
            obuf_last_q  <= 1'b0;
            wgt_done_q   <= 1'b0;
            act_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wgt_done_q <= out_fire && obuf_last_q && (obuf_dest_q == DEST_WGT);
            act_done_q <= out_fire && obuf_last_q && (obuf_dest_q == DEST_ACT);

            if (in_fire) begin
                obuf_valid_q <= 1'b1;
                obuf_data_q  <= s_axis_tdata;
                obuf_dest_q  <= dest_d;
                obuf_last_q  <= frame_end;
                cfg_q        <= cfg_d;
                cnt_q        <= frame_end ? '0 : cnt_d;
                if (frame_end)
                    state_q <= ST_IDLE;
                else
                    state_q <= (dest_d == DEST_WGT) ? ST_WGT : ST_ACT;
            end else if (out_fire) begin
                obuf_valid_q <= 1'b0;
            end

            if (i_err_clr)
                err_q <= 1'b0;
            else if (in_fire && len_err)
                err_q <= 1'b1;
        end
    end

    assign m_wgt_tdata  = obuf_data_q;
    assign m_act_tdata  = obuf_data_q;
    assign m_wgt_tvalid = obuf_valid_q && (obuf_dest_q == DEST_WGT);
    assign m_act_tvalid = obuf_valid_q && (obuf_dest_q == DEST_ACT);
    assign m_act_tlast  = obuf_valid_q && (obuf_dest_q == DEST_ACT) && obuf_last_q;
    assign o_wgt_done   = wgt_done_q;
    assign o_act_done   = act_done_q;
    assign o_err_len    = err_q;

endmodule

// File: tb/tb_axis_in_router.sv
// tb/tb_axis_in_router.sv - directed self-checking bench for axis_in_router
module tb_axis_in_router;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic [CNT_W-1:0]  cfg_wgt = '0;
    logic [CNT_W-1:0]  cfg_act = '0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              s_tlast = 1'b0;
    logic [DATA_W-1:0] m_wgt_tdata, m_act_tdata;
    logic              m_wgt_tvalid, m_act_tvalid, m_act_tlast;
    logic              m_wgt_tready = 1'b1;
    logic              m_act_tready = 1'b1;
    logic              wgt_done, act_done, err_len;
    logic              err_clr = 1'b0;

    int passed = 0;
    int total  = 0;
    int timeouts = 0;
    int cyc = 0;

    logic [DATA_W-1:0] wgt_q[$];
    logic [DATA_W-1:0] act_q[$];
    logic              actl_q[$];
    int wgt_done_n, act_done_n, wgt_done_cyc, wgt_hs_cyc, hold_viol, both_viol;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    axis_in_router #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_weight_dma_req(req),
        .cfg_wgt_beats(cfg_wgt), .cfg_act_beats(cfg_act),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_wgt_tdata(m_wgt_tdata), .m_wgt_tvalid(m_wgt_tvalid), .m_wgt_tready(m_wgt_tready),
        .m_act_tdata(m_act_tdata), .m_act_tvalid(m_act_tvalid), .m_act_tready(m_act_tready),
        .m_act_tlast(m_act_tlast),
        .o_wgt_done(wgt_done), .o_act_done(act_done), .o_err_len(err_len), .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_wgt_tvalid && m_wgt_tready) begin
            wgt_q.push_back(m_wgt_tdata);
            wgt_hs_cyc = cyc;
        end
        if (m_act_tvalid && m_act_tready) begin
            act_q.push_back(m_act_tdata);
            actl_q.push_back(m_act_tlast);
        end
        if (wgt_done) begin
            wgt_done_n++;
            wgt_done_cyc = cyc;
        end
        if (act_done) act_done_n++;
        if (m_wgt_tvalid && m_act_tvalid) both_viol++;
        if (prev_stall && (!m_act_tvalid || m_act_tdata != prev_data)) hold_viol++;
        prev_stall = m_act_tvalid && !m_act_tready;
        prev_data  = m_act_tdata;
    end

    task automatic clear_log();
        wgt_q.delete(); act_q.delete(); actl_q.delete();
        wgt_done_n = 0; act_done_n = 0; wgt_done_cyc = -1; wgt_hs_cyc = -2;
        hold_viol = 0; both_viol = 0; timeouts = 0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns just after the edge that accepted it (tvalid left high).
    task automatic push(input logic [DATA_W-1:0] d, input logic last);
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        timeouts++;
    endtask

    task automatic test_reset();
        s_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (s_tready !== 1'b0) $display("FAIL reset_tready got %b want 0", s_tready); else passed++;
        total++; if ({m_wgt_tvalid, m_act_tvalid, m_act_tlast} !== 3'b000)
            $display("FAIL reset_tvalid got %b want 000", {m_wgt_tvalid, m_act_tvalid, m_act_tlast}); else passed++;
        total++; if ({wgt_done, act_done, err_len} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {wgt_done, act_done, err_len}); else passed++;
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (s_tready !== 1'b1) $display("FAIL post_reset_tready got %b want 1", s_tready); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_wgt_frame();
        clear_log();
        req = 1'b1; cfg_wgt = 16'd4;
        for (int i = 0; i < 4; i++) push(64'h100 + 64'(i), i == 3);
        idle(4);
        total++; if (wgt_q.size() != 4) $display("FAIL wgt_count got %0d want 4", wgt_q.size()); else passed++;
        total++; if (wgt_q.size() == 4 && (wgt_q[0] !== 64'h100 || wgt_q[3] !== 64'h103))
            $display("FAIL wgt_data got %h..%h want 100..103", wgt_q[0], wgt_q[3]); else passed++;
        total++; if (act_q.size() != 0) $display("FAIL wgt_act_leak got %0d want 0", act_q.size()); else passed++;
        total++; if (wgt_done_n != 1) $display("FAIL wgt_done_count got %0d want 1", wgt_done_n); else passed++;
        total++; if (wgt_done_cyc != wgt_hs_cyc + 1)
            $display("FAIL wgt_done_timing got %0d want %0d", wgt_done_cyc, wgt_hs_cyc + 1); else passed++;
        total++; if (err_len !== 1'b0) $display("FAIL wgt_err got %b want 0", err_len); else passed++;
        total++; if (timeouts != 0) $display("FAIL wgt_timeout got %0d want 0", timeouts); else passed++;
    endtask

    task automatic test_act_short();
        logic exp_l[5];
        int bad;
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        clear_log();
        req = 1'b0; cfg_act = 16'd3;
        push(64'h200, 1'b0); push(64'h201, 1'b1);
        push(64'h202, 1'b0); push(64'h203, 1'b0); push(64'h204, 1'b1);
        idle(4);
        bad = 0;
        if (act_q.size() != 5) bad = 99;
        else for (int i = 0; i < 5; i++)
            if (act_q[i] !== 64'h200 + 64'(i) || actl_q[i] !== exp_l[i]) bad++;
        total++; if (bad != 0) $display("FAIL act_short_beats got %0d bad want 0", bad); else passed++;
        total++; if (act_done_n != 2) $display("FAIL act_short_done got %0d want 2", act_done_n); else passed++;
        total++; if (err_len !== 1'b1) $display("FAIL act_short_err got %b want 1", err_len); else passed++;
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        total++; if (err_len !== 1'b0) $display("FAIL err_clear got %b want 0", err_len); else passed++;
    endtask

    task automatic test_count_end_and_clr();
        clear_log();
        req = 1'b0; cfg_act = 16'd2;
        push(64'h300, 1'b0); push(64'h301, 1'b0);
        idle(4);
        total++; if (actl_q.size() != 2 || actl_q[0] !== 1'b0 || actl_q[1] !== 1'b1)
            $display("FAIL count_end_tlast got n=%0d want 2 beats tlast on 2nd", actl_q.size()); else passed++;
        total++; if (act_done_n != 1) $display("FAIL count_end_done got %0d want 1", act_done_n); else passed++;
        total++; if (err_len !== 1'b1) $display("FAIL count_end_err got %b want 1", err_len); else passed++;
        err_clr = 1'b1;
        push(64'h302, 1'b1);
        s_tvalid = 1'b0;
        @(posedge clk); #1; err_clr = 1'b0;
        idle(2);
        total++; if (err_len !== 1'b0) $display("FAIL clr_priority got %b want 0", err_len); else passed++;
    endtask

    task automatic test_stall();
        int bad;
        clear_log();
        req = 1'b0; cfg_act = 16'd8;
        fork
            begin
                for (int i = 0; i < 8; i++) push(64'h500 + 64'(i), i == 7);
                s_tvalid = 1'b0; s_tlast = 1'b0;
            end
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    m_act_tready = ~m_act_tready;
                end
            end
        join
        m_act_tready = 1'b1;
        idle(4);
        bad = 0;
        if (act_q.size() != 8) bad = 99;
        else for (int i = 0; i < 8; i++)
            if (act_q[i] !== 64'h500 + 64'(i) || actl_q[i] !== (i == 7)) bad++;
        total++; if (bad != 0) $display("FAIL stall_order got %0d bad (n=%0d) want 0", bad, act_q.size()); else passed++;
        total++; if (hold_viol != 0) $display("FAIL stall_hold got %0d want 0", hold_viol); else passed++;
        total++; if (act_done_n != 1) $display("FAIL stall_done got %0d want 1", act_done_n); else passed++;
        total++; if (err_len !== 1'b0 || timeouts != 0)
            $display("FAIL stall_err got err=%b to=%0d want 0/0", err_len, timeouts); else passed++;
    endtask

    task automatic test_req_flip();
        clear_log();
        req = 1'b0; cfg_act = 16'd4; cfg_wgt = 16'd0;
        push(64'h400, 1'b0); push(64'h401, 1'b0);
        req = 1'b1; cfg_act = 16'd2;
        push(64'h402, 1'b0); push(64'h403, 1'b1);
        push(64'h404, 1'b1);
        idle(4);
        total++; if (act_q.size() != 4 || act_q[3] !== 64'h403 || actl_q[3] !== 1'b1 || actl_q[1] !== 1'b0)
            $display("FAIL flip_act got n=%0d want 4 beats ending 403 with tlast", act_q.size()); else passed++;
        total++; if (wgt_q.size() != 1 || wgt_q[0] !== 64'h404)
            $display("FAIL flip_wgt got n=%0d want one beat 404", wgt_q.size()); else passed++;
        total++; if (act_done_n != 1 || wgt_done_n != 1)
            $display("FAIL flip_done got act=%0d wgt=%0d want 1/1", act_done_n, wgt_done_n); else passed++;
        total++; if (err_len !== 1'b0 || both_viol != 0)
            $display("FAIL flip_err got err=%b both=%0d want 0/0", err_len, both_viol); else passed++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        req = 1'b1; cfg_wgt = 16'd4;
        push(64'h600, 1'b0); push(64'h601, 1'b0); push(64'h602, 1'b0);
        s_tvalid = 1'b0; rst = 1'b1; m_wgt_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if ({s_tready, m_wgt_tvalid, m_act_tvalid, m_act_tlast, wgt_done, act_done, err_len} !== 7'b0)
            $display("FAIL mid_reset_outputs got %b want 0000000",
                     {s_tready, m_wgt_tvalid, m_act_tvalid, m_act_tlast, wgt_done, act_done, err_len}); else passed++;
        @(posedge clk); #1;
        rst = 1'b0; m_wgt_tready = 1'b1;
        for (int i = 0; i < 4; i++) push(64'h610 + 64'(i), i == 3);
        idle(4);
        total++; if (wgt_q.size() != 6 || wgt_q[1] !== 64'h601 || wgt_q[2] !== 64'h610 || wgt_q[5] !== 64'h613)
            $display("FAIL mid_reset_beats got n=%0d want 6 (600,601,610..613)", wgt_q.size()); else passed++;
        total++; if (wgt_done_n != 1 || err_len !== 1'b0)
            $display("FAIL mid_reset_frame got done=%0d err=%b want 1/0", wgt_done_n, err_len); else passed++;
    endtask

    task automatic test_long_tlast_only();
        int bad;
        clear_log();
        req = 1'b0; cfg_act = 16'd0;
        for (int i = 0; i < 300; i++) push(64'h1000 + 64'(i), i == 299);
        idle(4);
        bad = 0;
        if (act_q.size() != 300) bad = 999;
        else for (int i = 0; i < 300; i++)
            if (act_q[i] !== 64'h1000 + 64'(i) || actl_q[i] !== (i == 299)) bad++;
        total++; if (bad != 0) $display("FAIL long_beats got %0d bad (n=%0d) want 0", bad, act_q.size()); else passed++;
        total++; if (act_done_n != 1) $display("FAIL long_done got %0d want 1", act_done_n); else passed++;
        total++; if (err_len !== 1'b0) $display("FAIL long_err got %b want 0", err_len); else passed++;
    endtask

    initial begin
        test_reset();
        test_wgt_frame();
        test_act_short();
        test_count_end_and_clr();
        test_stall();
        test_req_flip();
        test_reset_mid();
        test_long_tlast_only();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
